// File: rtl/plane_draw_engine_if.sv
// Plane control <-> draw engine <-> VGA plot port signal bundle.
// The master drives a frame request; the slave (draw engine) returns pixels and status.
interface plane_draw_engine_if #(
    parameter int NUM_PLANES = 10
);
    logic                      start;
    logic [1:0]                op;
    logic [8*NUM_PLANES-1:0]   x_flat;
    logic [8*NUM_PLANES-1:0]   y_flat;
    logic [NUM_PLANES-1:0]     vis;
    logic [7:0]                vga_x;
    logic [7:0]                vga_y;
    logic [2:0]                colour;
    logic                      plot;
    logic                      busy;
    logic                      done;

    modport master (
        output start, op, x_flat, y_flat, vis,
        input  vga_x, vga_y, colour, plot, busy, done
    );

    modport slave (
        input  start, op, x_flat, y_flat, vis,
        output vga_x, vga_y, colour, plot, busy, done
    );
endinterface

// File: rtl/plane_draw_engine.sv
// Walks the latched plane list and streams one SPR_W x SPR_H sprite per visible
// plane to the VGA plot port, one pixel per clock.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IDLE | waiting for start; clears busy one cycle after done
//  S_SCAN | one cycle per invisible plane, one per sprite pixel otherwise
//  S_DONE | pass finished; raises done for one cycle, back to S_IDLE
module plane_draw_engine #(
    parameter int         NUM_PLANES  = 10,
    parameter int         SPR_W       = 4,
    parameter int         SPR_H       = 4,
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter logic [2:0] DRAW_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR   = 3'b000
) (
    input  logic                clk,
    input  logic                reset_n,
    plane_draw_engine_if.slave  bus
);

    localparam int PW  = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1;
    localparam int DXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int DYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    localparam logic [PW-1:0]  LAST_PLANE = PW'(NUM_PLANES - 1);
    localparam logic [DXW-1:0] LAST_DX    = DXW'(SPR_W - 1);
    localparam logic [DYW-1:0] LAST_DY    = DYW'(SPR_H - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [7:0]              snap_x [NUM_PLANES];
    logic [7:0]              snap_y [NUM_PLANES];
    logic [NUM_PLANES-1:0]   snap_vis;
    logic                    snap_draw;
    logic [PW-1:0]           plane;
    logic [DXW-1:0]          dx;
    logic [DYW-1:0]          dy;

    logic [8:0]              sum_x;
    logic [8:0]              sum_y;
    logic                    on_screen;

    // 9-bit sums so sprites hanging off the right/bottom edge clip instead of wrapping
    assign sum_x     = {1'b0, snap_x[plane]} + 9'(dx);
    assign sum_y     = {1'b0, snap_y[plane]} + 9'(dy);
    assign on_screen = (sum_x < 9'(SCREEN_W)) && (sum_y < 9'(SCREEN_H));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            for (int i = 0; i < NUM_PLANES; i++) begin
                snap_x[i] <= '0;
                snap_y[i] <= '0;
            end
            snap_vis   <= '0;
            snap_draw  <= 1'b0;
            plane      <= '0;
            dx         <= '0;
            dy         <= '0;
            bus.vga_x  <= '0;
            bus.vga_y  <= '0;
            bus.colour <= '0;
            bus.plot   <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            bus.plot <= 1'b0;
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // busy is still high in the cycle done is shown; start is ignored there
                    bus.busy <= 1'b0;
                    if (bus.start && !bus.busy) begin
                        for (int i = 0; i < NUM_PLANES; i++) begin
                            snap_x[i] <= bus.x_flat[8*i +: 8];
                            snap_y[i] <= bus.y_flat[8*i +: 8];
                        end
                        snap_vis  <= bus.vis;
                        snap_draw <= bus.op[0];
                        plane     <= '0;
                        dx        <= '0;
                        dy        <= '0;
                        bus.busy  <= 1'b1;
                        state     <= bus.op[1] ? S_DONE : S_SCAN;
                    end
                end

                S_SCAN: begin
                    if (!snap_vis[plane]) begin
                        if (plane == LAST_PLANE) state <= S_DONE;
                        else                     plane <= plane + 1'b1;
                    end else begin
                        if (on_screen) begin
                            bus.plot   <= 1'b1;
                            bus.vga_x  <= sum_x[7:0];
                            bus.vga_y  <= sum_y[7:0];
                            bus.colour <= snap_draw ? DRAW_COLOUR : BG_COLOUR;
                        end
                        if (dx == LAST_DX) begin
                            dx <= '0;
                            if (dy == LAST_DY) begin
                                dy <= '0;
                                if (plane == LAST_PLANE) state <= S_DONE;
                                else                     plane <= plane + 1'b1;
                            end else begin
                                dy <= dy + 1'b1;
                            end
                        end else begin
                            dx <= dx + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    bus.done <= 1'b1;
                    state    <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
